// File: rtl/piezo_pkg.sv
// Shared types, note codes, note-frequency table and default melody for the
// piezo melody sequencer and its note lookup.
package piezo_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP, FIN} state_t;

  localparam int unsigned NOTE_W  = 4;
  localparam int unsigned DUR_W   = 2;
  localparam int unsigned ENTRY_W = NOTE_W + DUR_W;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS4  = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS4  = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS4  = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS4  = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS4  = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd12;

  // Equal-tempered frequencies of C4..B4 in milli-Hz.
  function automatic longint unsigned note_mhz(input int unsigned note);
    case (note)
      1:       return 64'd261626;
      2:       return 64'd277183;
      3:       return 64'd293665;
      4:       return 64'd311127;
      5:       return 64'd329628;
      6:       return 64'd349228;
      7:       return 64'd369994;
      8:       return 64'd391995;
      9:       return 64'd415305;
      10:      return 64'd440000;
      11:      return 64'd466164;
      12:      return 64'd493883;
      default: return 64'd0;
    endcase
  endfunction

  // Half-period count for a generator that toggles after LIMIT+1 cycles.
  function automatic longint unsigned note_limit(input longint unsigned clk_hz,
                                                 input int unsigned note);
    if (note == 0 || note > 12) return 64'd0;
    return (clk_hz * 64'd1000) / (64'd2 * note_mhz(note)) - 64'd1;
  endfunction

  // Entry 0 occupies the least significant bits.
  localparam logic [8*ENTRY_W-1:0] DEFAULT_MELODY = {
    NOTE_REST, 2'd0,
    NOTE_C4,   2'd3,
    NOTE_E4,   2'd1,
    NOTE_G4,   2'd2,
    NOTE_REST, 2'd1,
    NOTE_G4,   2'd1,
    NOTE_E4,   2'd1,
    NOTE_C4,   2'd1
  };

endpackage

// File: rtl/piezo_note_lut.sv
// Combinational map from a melody note code to the tone generator's
// half-period limit; rest and unused codes give 0.
module piezo_note_lut
  import piezo_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 1_000_000,
  parameter int unsigned LIMIT_W = 16
) (
  input  logic [NOTE_W-1:0]  NOTE,
  output logic [LIMIT_W-1:0] LIMIT
);

  always_comb begin
    LIMIT = '0;
    for (int unsigned k = 1; k <= 12; k++) begin
      if (NOTE == NOTE_W'(k)) LIMIT = LIMIT_W'(note_limit(64'(CLK_HZ), k));
    end
  end

endmodule

// File: rtl/piezo_melody_seq.sv
// Melody sequencer driving LIMIT/TONE_EN of the piezo tone generator.
// Define PIEZO_MELODY_REPEAT_EN to loop the melody instead of ending in FIN/DONE.
module piezo_melody_seq
  import piezo_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 1_000_000,
  parameter int unsigned BEAT_CYCLES = 100_000,
  parameter int unsigned GAP_CYCLES  = 10_000,
  parameter int unsigned NUM_NOTES   = 8,
  parameter int unsigned LIMIT_W     = 16,
  parameter logic [NUM_NOTES*ENTRY_W-1:0] MELODY = DEFAULT_MELODY
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         START,
  input  logic                         STOP,
  output logic [LIMIT_W-1:0]           LIMIT,
  output logic                         TONE_EN,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [$clog2(NUM_NOTES)-1:0] NOTE_IDX
);

  localparam int unsigned IDX_W = $clog2(NUM_NOTES);
  localparam int unsigned TMAX  = (3*BEAT_CYCLES > GAP_CYCLES) ? 3*BEAT_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W = $clog2(TMAX + 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef PIEZO_MELODY_REPEAT_EN
  localparam logic REPEAT = 1'b1;
`else
  localparam logic REPEAT = 1'b0;
`endif

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [DUR_W-1:0]   cur_dur;
  entry_t             nxt;
  entry_t             first;
  logic               last;
  logic               expire;
  logic [TMR_W-1:0]   play_last;
  logic [NOTE_W-1:0]  lut_note;
  logic [LIMIT_W-1:0] lut_limit;

  always_comb begin
    cur_dur = '0;
    nxt     = '0;
    first   = MELODY[ENTRY_W-1:0];
    for (int unsigned k = 0; k < NUM_NOTES; k++) begin
      if (IDX_W'(k) == NOTE_IDX) cur_dur = MELODY[k*ENTRY_W +: DUR_W];
      if (k == 32'(NOTE_IDX) + 32'd1) nxt = MELODY[k*ENTRY_W +: ENTRY_W];
    end
    last      = (NOTE_IDX == IDX_W'(NUM_NOTES - 1)) || (nxt.dur == '0);
    play_last = TMR_W'(32'(cur_dur) * BEAT_CYCLES - 32'd1);
    expire    = (state == PLAY) ? (timer == play_last) : (timer == GAP_LAST);
    // The single LUT always looks at whichever entry would be loaded next.
    lut_note  = (state == IDLE || last) ? first.note : nxt.note;
  end

  piezo_note_lut #(
    .CLK_HZ  (CLK_HZ),
    .LIMIT_W (LIMIT_W)
  ) u_lut (
    .NOTE  (lut_note),
    .LIMIT (lut_limit)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      timer    <= '0;
      LIMIT    <= '0;
      TONE_EN  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      NOTE_IDX <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START && !STOP) begin
            timer    <= '0;
            NOTE_IDX <= '0;
            if (first.dur == '0) begin
              state <= FIN;
              DONE  <= 1'b1;
            end else begin
              state   <= PLAY;
              BUSY    <= 1'b1;
              LIMIT   <= lut_limit;
              TONE_EN <= (first.note != '0);
            end
          end
        end
        PLAY, GAP: begin
          if (STOP) begin
            state    <= IDLE;
            timer    <= '0;
            TONE_EN  <= 1'b0;
            BUSY     <= 1'b0;
            NOTE_IDX <= '0;
          end else if (!expire) begin
            timer <= timer + 1'b1;
          end else begin
            timer <= '0;
            if (state == PLAY && GAP_CYCLES != 0) begin
              state   <= GAP;
              TONE_EN <= 1'b0;
            end else if (last && !REPEAT) begin
              state   <= FIN;
              DONE    <= 1'b1;
              BUSY    <= 1'b0;
              TONE_EN <= 1'b0;
            end else begin
              state    <= PLAY;
              NOTE_IDX <= last ? '0 : NOTE_IDX + 1'b1;
              LIMIT    <= lut_limit;
              TONE_EN  <= (lut_note != '0);
            end
          end
        end
        FIN: begin
          state <= IDLE;
          if (STOP) NOTE_IDX <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Directed self-checking bench for piezo_melody_seq with short beats.
module tb_piezo_melody_seq;

  localparam int unsigned NN = 8;

  // A4/1, rest/2, C4/3, end marker, then filler that must never play.
  localparam logic [NN*6-1:0] MEL_A = {
    4'd12, 2'd1, 4'd12, 2'd1, 4'd12, 2'd1, 4'd12, 2'd1,
    4'd0,  2'd0, 4'd1,  2'd3, 4'd0,  2'd2, 4'd10, 2'd1
  };
  // Notes 1..8, one beat each, no end marker.
  localparam logic [NN*6-1:0] MEL_B = {
    4'd8, 2'd1, 4'd7, 2'd1, 4'd6, 2'd1, 4'd5, 2'd1,
    4'd4, 2'd1, 4'd3, 2'd1, 4'd2, 2'd1, 4'd1, 2'd1
  };
  // End marker in entry 0.
  localparam logic [NN*6-1:0] MEL_C = {
    4'd1, 2'd1, 4'd1, 2'd1, 4'd1, 2'd1, 4'd1, 2'd1,
    4'd1, 2'd1, 4'd1, 2'd1, 4'd1, 2'd1, 4'd10, 2'd0
  };

  logic CLK = 1'b0;
  logic RESET;
  logic start_a, stop_a, start_b, stop_b, start_c, stop_c;
  logic [15:0] lim_a, lim_b, lim_c;
  logic ten_a, ten_b, ten_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [2:0] idx_a, idx_b, idx_c;

  int sel;
  logic [15:0] o_lim;
  logic o_ten, o_busy, o_done;
  logic [2:0] o_idx;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  piezo_melody_seq #(.CLK_HZ(1_000_000), .BEAT_CYCLES(10), .GAP_CYCLES(2),
                     .NUM_NOTES(NN), .LIMIT_W(16), .MELODY(MEL_A)) dut_a (
    .CLK(CLK), .RESET(RESET), .START(start_a), .STOP(stop_a), .LIMIT(lim_a),
    .TONE_EN(ten_a), .BUSY(busy_a), .DONE(done_a), .NOTE_IDX(idx_a));

  piezo_melody_seq #(.CLK_HZ(1_000_000), .BEAT_CYCLES(10), .GAP_CYCLES(2),
                     .NUM_NOTES(NN), .LIMIT_W(16), .MELODY(MEL_B)) dut_b (
    .CLK(CLK), .RESET(RESET), .START(start_b), .STOP(stop_b), .LIMIT(lim_b),
    .TONE_EN(ten_b), .BUSY(busy_b), .DONE(done_b), .NOTE_IDX(idx_b));

  piezo_melody_seq #(.CLK_HZ(1_000_000), .BEAT_CYCLES(10), .GAP_CYCLES(2),
                     .NUM_NOTES(NN), .LIMIT_W(16), .MELODY(MEL_C)) dut_c (
    .CLK(CLK), .RESET(RESET), .START(start_c), .STOP(stop_c), .LIMIT(lim_c),
    .TONE_EN(ten_c), .BUSY(busy_c), .DONE(done_c), .NOTE_IDX(idx_c));

  always_comb begin
    o_lim = lim_a; o_ten = ten_a; o_busy = busy_a; o_done = done_a; o_idx = idx_a;
    if (sel == 1) begin
      o_lim = lim_b; o_ten = ten_b; o_busy = busy_b; o_done = done_b; o_idx = idx_b;
    end else if (sel == 2) begin
      o_lim = lim_c; o_ten = ten_c; o_busy = busy_c; o_done = done_c; o_idx = idx_c;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Checks the selected DUT for n consecutive cycles; lim < 0 skips LIMIT.
  task automatic hold(input string tag, input int n, input logic ten, input int lim,
                      input int idx, input logic busy, input logic done);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".ten"}, 32'(o_ten), 32'(ten));
      if (lim >= 0) chk({tag, ".lim"}, 32'(o_lim), lim);
      chk({tag, ".idx"}, 32'(o_idx), idx);
      chk({tag, ".busy"}, 32'(o_busy), 32'(busy));
      chk({tag, ".done"}, 32'(o_done), 32'(done));
      tick();
    end
  endtask

  int lim_tab [8] = '{1910, 1802, 1701, 1606, 1515, 1430, 1350, 1274};
  int loops;

  initial begin
    RESET = 1'b1;
    start_a = 1'b0; stop_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0;
    start_c = 1'b0; stop_c = 1'b0;
    sel = 0;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #0;
      hold("reset", 1, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    RESET = 1'b0;
    tick();

    // Reset in the middle of note 3 of melody B.
    sel = 1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hold("pre_rst", 10, 1'b1, lim_tab[i], i, 1'b1, 1'b0);
      hold("pre_rst_gap", 2, 1'b0, lim_tab[i], i, 1'b1, 1'b0);
    end
    hold("at_idx3", 1, 1'b1, lim_tab[3], 3, 1'b1, 1'b0);
    RESET = 1'b1; tick(); RESET = 1'b0;
    hold("mid_rst", 3, 1'b0, 0, 0, 1'b0, 1'b0);

    // Full table, with a START pulse during note 2 that must be ignored.
`ifdef PIEZO_MELODY_REPEAT_EN
    loops = 3;
`else
    loops = 1;
`endif
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int l = 0; l < loops; l++) begin
      for (int i = 0; i < 8; i++) begin
        if (l == 0 && i == 2) begin
          hold("full", 3, 1'b1, lim_tab[i], i, 1'b1, 1'b0);
          start_b = 1'b1;
          hold("full_restart", 1, 1'b1, lim_tab[i], i, 1'b1, 1'b0);
          start_b = 1'b0;
          hold("full", 6, 1'b1, lim_tab[i], i, 1'b1, 1'b0);
        end else begin
          hold("full", 10, 1'b1, lim_tab[i], i, 1'b1, 1'b0);
        end
        hold("full_gap", 2, 1'b0, lim_tab[i], i, 1'b1, 1'b0);
      end
    end
`ifdef PIEZO_MELODY_REPEAT_EN
    hold("wrap", 2, 1'b1, lim_tab[0], 0, 1'b1, 1'b0);
    stop_b = 1'b1; tick(); stop_b = 1'b0;
    hold("rep_stop", 3, 1'b0, -1, 0, 1'b0, 1'b0);
`else
    hold("full_fin", 1, 1'b0, lim_tab[7], 7, 1'b0, 1'b1);
    hold("full_idle", 3, 1'b0, lim_tab[7], 7, 1'b0, 1'b0);
`endif

    // Melody A: note, rest, long note, end marker.
    sel = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    hold("a4", 10, 1'b1, 1135, 0, 1'b1, 1'b0);
    hold("a4_gap", 2, 1'b0, 1135, 0, 1'b1, 1'b0);
    hold("rest", 20, 1'b0, 0, 1, 1'b1, 1'b0);
    hold("rest_gap", 2, 1'b0, 0, 1, 1'b1, 1'b0);
    hold("c4", 30, 1'b1, 1910, 2, 1'b1, 1'b0);
    hold("c4_gap", 2, 1'b0, 1910, 2, 1'b1, 1'b0);
`ifdef PIEZO_MELODY_REPEAT_EN
    hold("a_wrap", 3, 1'b1, 1135, 0, 1'b1, 1'b0);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
`else
    hold("a_fin", 1, 1'b0, 1910, 2, 1'b0, 1'b1);
    hold("a_idle", 3, 1'b0, 1910, 2, 1'b0, 1'b0);
`endif

    // STOP during cycle 5 of the first note, then START+STOP together.
    start_a = 1'b1; tick(); start_a = 1'b0;
    hold("s_note", 4, 1'b1, 1135, 0, 1'b1, 1'b0);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    hold("s_after", 80, 1'b0, -1, 0, 1'b0, 1'b0);
    start_a = 1'b1; stop_a = 1'b1; tick(); start_a = 1'b0; stop_a = 1'b0;
    hold("start_stop", 5, 1'b0, -1, 0, 1'b0, 1'b0);

    // End marker in entry 0: straight to FIN.
    sel = 2;
    start_c = 1'b1; tick(); start_c = 1'b0;
    hold("c_fin", 1, 1'b0, 0, 0, 1'b0, 1'b1);
    hold("c_idle", 3, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piezo_melody_seq.md
Name: piezo_melody_seq

Overview:
- Upstream sequencer for the piezo tone generator.
- Steps through a fixed melody table and drives the tone generator's half-period limit (LIMIT) plus a tone-enable.
- Integration ANDs the tone-generator output with TONE_EN, so rests and gaps are silent.
- Used for watch alarm and chime sounds. START begins playback, STOP aborts it, DONE pulses on natural completion.

Parameters:
- CLK_HZ, 1_000_000, system clock frequency; used to derive note limits.
- BEAT_CYCLES, 100_000, clock cycles per duration unit.
- GAP_CYCLES, 10_000, silent cycles after each note; 0 means no gap.
- NUM_NOTES, 8, melody table depth.
- LIMIT_W, 16, width of LIMIT output.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset, sampled on posedge CLK
- START  in  1  start request; acted on only in IDLE
- STOP  in  1  abort request
- LIMIT  out  LIMIT_W  half-period count for the tone generator
- TONE_EN  out  1  high while a non-rest note sounds
- BUSY  out  1  high in PLAY and GAP
- DONE  out  1  one-cycle pulse on natural end of melody
- NOTE_IDX  out  $clog2(NUM_NOTES)  current table index

Behaviour:
- Table entry: {NOTE[3:0], DUR[1:0]}.
  - NOTE 0 = rest; NOTE 1..12 = C4..B4.
  - DUR 0 = end marker; otherwise the note lasts DUR*BEAT_CYCLES cycles.
- Note LUT: LIMIT = CLK_HZ/(2*f) - 1, integer truncation, where f is the equal-tempered frequency. This matches a generator that toggles after LIMIT+1 cycles. Rest gives LIMIT 0.
- Reset: state IDLE; LIMIT, TONE_EN, BUSY, DONE, NOTE_IDX all 0; timers cleared. Reset mid-playback behaves identically.
- States:
  - IDLE -> PLAY on START.
  - PLAY -> GAP when the duration timer expires and GAP_CYCLES > 0.
  - PLAY -> next PLAY directly when the timer expires and GAP_CYCLES = 0.
  - GAP -> PLAY (next index) when the gap timer expires.
  - PLAY/GAP -> FIN when the index advance would pass NUM_NOTES-1, or the next entry has DUR 0.
  - FIN -> IDLE after 1 cycle.
- Latency: START sampled at edge t; from edge t+1 the outputs are BUSY=1, NOTE_IDX=0, LIMIT=lut(NOTE0), TONE_EN=(NOTE0!=0).
- Entry 0 with DUR 0: START goes to FIN directly (DONE pulses at t+1, BUSY stays 0).
- Timer: the PLAY timer counts 0..DUR*BEAT_CYCLES-1, so each note occupies exactly DUR*BEAT_CYCLES cycles with TONE_EN at the note value. GAP occupies exactly GAP_CYCLES cycles with TONE_EN=0 and LIMIT held.
- FIN: DONE=1 for one cycle; BUSY=0, TONE_EN=0; LIMIT holds its last value.
- STOP in PLAY, GAP or FIN: next cycle is IDLE, TONE_EN=0, BUSY=0, no DONE pulse, NOTE_IDX=0. STOP in IDLE has no effect.
- START and STOP in the same cycle: STOP wins.
- START while BUSY is ignored; no restart.
- Timer widths are sized for 3*BEAT_CYCLES without overflow.

Optional Feature:
- PIEZO_MELODY_REPEAT_EN.
- Defined: at melody end, restart at index 0 in PLAY instead of FIN. No DONE pulse. Loops until STOP or RESET.
- Undefined: single pass ending in FIN/DONE as above.

Decomposition:
- Shared package piezo_pkg:
  - state enum (IDLE, PLAY, GAP, FIN)
  - note code constants
  - note-frequency table (milli-Hz)
  - default melody ROM constant
  - entry field widths
- Sub-module piezo_note_lut: combinational NOTE -> LIMIT map parameterised by CLK_HZ and LIMIT_W; instantiated once.

Test Plan (bench overrides BEAT_CYCLES=10, GAP_CYCLES=2, CLK_HZ=1_000_000):
- Reset during PLAY at NOTE_IDX 3 -> next cycle all outputs 0, IDLE; subsequent START plays from index 0.
- Melody {A4,DUR1},{rest,DUR2},{C4,DUR3},{x,DUR0}; START pulse -> LIMIT=1135, TONE_EN=1 for 10 cycles; TONE_EN=0 for 2; rest TONE_EN=0 for 20+2; LIMIT=1910, TONE_EN=1 for 30; gap 2; DONE=1 one cycle; BUSY low after.
- Full 8-entry table with no DUR0 marker -> NOTE_IDX runs 0..7; DONE after the index-7 gap; NOTE_IDX never wraps.
- STOP at cycle 5 of the first note -> next cycle TONE_EN=0, BUSY=0; DONE never asserts; START+STOP in the same cycle from IDLE -> stays IDLE.
- START pulsed again mid-melody -> ignored; NOTE_IDX and timers unaffected.
- With PIEZO_MELODY_REPEAT_EN -> after the last entry NOTE_IDX returns to 0 with TONE_EN per note 0; DONE stays 0 across 3 loops; STOP ends playback.
